// File: rtl/regbank_pkg.sv
// Shared defaults and packed-port helpers for the multi-port register bank.
package regbank_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 5;
    localparam int unsigned DEF_NREAD  = 2;

    // Low bit of port `port` inside a bus of equal-width fields packed LSB-first.
    function automatic int unsigned slice_lo(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/regbank_read_port.sv
// One combinational read port: storage mux, write-to-read bypass and hardwired-zero handling.
module regbank_read_port
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]                       addr,
    input  logic [(1<<ADDR_W)-1:0][DATA_W-1:0]      regs,
    input  logic [(1<<ADDR_W)-1:0]                  busy_bits,
    input  logic                                    wr_en0,
    input  logic [ADDR_W-1:0]                       wr_addr0,
    input  logic [DATA_W-1:0]                       wr_data0,
    input  logic                                    wr_en1,
    input  logic [ADDR_W-1:0]                       wr_addr1,
    input  logic [DATA_W-1:0]                       wr_data1,
    input  logic                                    claim_en,
    input  logic [ADDR_W-1:0]                       claim_addr,
    output logic [DATA_W-1:0]                       data,
    output logic                                    busy
);

    logic is_zero;
    logic hit0;
    logic hit1;

    always_comb begin
        is_zero = (ZERO_REG != 0) && (addr == '0);
        hit0    = (BYPASS != 0) && wr_en0 && (wr_addr0 == addr);
        hit1    = (BYPASS != 0) && wr_en1 && (wr_addr1 == addr);

        data = regs[addr];
        busy = busy_bits[addr];

        if (hit1) begin
            data = wr_data1;
        end else if (hit0) begin
            data = wr_data0;
        end

        // A bypassed write retires the old producer; only a same-cycle claim keeps it busy.
        if (hit0 || hit1) begin
            busy = claim_en && (claim_addr == addr);
        end

        if (is_zero) begin
            data = '0;
            busy = 1'b0;
        end
    end

endmodule

// File: rtl/regbank_mp.sv
// Multi-port register bank: storage, two prioritised write ports, busy scoreboard and busy counter.
module regbank_mp
    import regbank_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NREAD    = DEF_NREAD,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wr_en0,
    input  logic [ADDR_W-1:0]         wr_addr0,
    input  logic [DATA_W-1:0]         wr_data0,
    input  logic                      wr_en1,
    input  logic [ADDR_W-1:0]         wr_addr1,
    input  logic [DATA_W-1:0]         wr_data1,
    input  logic                      claim_en,
    input  logic [ADDR_W-1:0]         claim_addr,
    input  logic [NREAD*ADDR_W-1:0]   rd_addr,
    output logic [NREAD*DATA_W-1:0]   rd_data,
    output logic [NREAD-1:0]          rd_busy,
    output logic [ADDR_W:0]           busy_count
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0][DATA_W-1:0] regs;
    logic [DEPTH-1:0][DATA_W-1:0] regs_next;
    logic [DEPTH-1:0]             busy;
    logic [DEPTH-1:0]             busy_next;
    logic [ADDR_W:0]              count_next;
    logic                         wr0_ok;
    logic                         wr1_ok;
    logic                         claim_ok;

    always_comb begin
        wr0_ok   = wr_en0   && !((ZERO_REG != 0) && (wr_addr0   == '0));
        wr1_ok   = wr_en1   && !((ZERO_REG != 0) && (wr_addr1   == '0));
        claim_ok = claim_en && !((ZERO_REG != 0) && (claim_addr == '0));

        regs_next = regs;
        busy_next = busy;

        // Port 1 applied last so it wins a same-address collision; claim last so a new producer wins.
        if (wr0_ok) begin
            regs_next[wr_addr0] = wr_data0;
            busy_next[wr_addr0] = 1'b0;
        end
        if (wr1_ok) begin
            regs_next[wr_addr1] = wr_data1;
            busy_next[wr_addr1] = 1'b0;
        end
        if (claim_ok) begin
            busy_next[claim_addr] = 1'b1;
        end

        count_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_next = count_next + {{ADDR_W{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            regs       <= '0;
            busy       <= '0;
            busy_count <= '0;
        end else begin
            regs       <= regs_next;
            busy       <= busy_next;
            busy_count <= count_next;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        regbank_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (BYPASS)
        ) u_port (
            .addr       (rd_addr[slice_lo(g, ADDR_W) +: ADDR_W]),
            .regs       (regs),
            .busy_bits  (busy),
            .wr_en0     (wr_en0),
            .wr_addr0   (wr_addr0),
            .wr_data0   (wr_data0),
            .wr_en1     (wr_en1),
            .wr_addr1   (wr_addr1),
            .wr_data1   (wr_data1),
            .claim_en   (claim_en),
            .claim_addr (claim_addr),
            .data       (rd_data[slice_lo(g, DATA_W) +: DATA_W]),
            .busy       (rd_busy[g])
        );
    end

endmodule

// File: tb/tb_regbank_mp.sv
// Scoreboard bench for regbank_mp: bypassing and non-bypassing instances driven in lockstep.
module tb_regbank_mp;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NR = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset_n;
    logic            wr_en0, wr_en1, claim_en;
    logic [AW-1:0]   wr_addr0, wr_addr1, claim_addr;
    logic [DW-1:0]   wr_data0, wr_data1;
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data, rd_data_nb;
    logic [NR-1:0]    rd_busy, rd_busy_nb;
    logic [AW:0]      busy_count, busy_count_nb;

    regbank_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .busy_count(busy_count)
    );

    regbank_mp #(.DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clock(clock), .reset_n(reset_n),
        .wr_en0(wr_en0), .wr_addr0(wr_addr0), .wr_data0(wr_data0),
        .wr_en1(wr_en1), .wr_addr1(wr_addr1), .wr_data1(wr_data1),
        .claim_en(claim_en), .claim_addr(claim_addr),
        .rd_addr(rd_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
        .busy_count(busy_count_nb)
    );

    typedef struct {
        int          step;
        logic [63:0] data;
        logic [1:0]  busy;
        logic [63:0] data_nb;
        logic [1:0]  busy_nb;
        logic [5:0]  cnt;
    } exp_t;

    exp_t q[$];

    // Reference architectural state.
    logic [31:0] mreg [32];
    logic        mbusy[32];

    int checks = 0;
    int errors = 0;
    int step   = 0;
    bit done   = 0;

    task automatic chk(input string nm, input int stp, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h expected %0h", nm, stp, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_data(input int a, input bit byp);
        if (a == 0) return '0;
        if (byp && wr_en1 && int'(wr_addr1) == a) return wr_data1;
        if (byp && wr_en0 && int'(wr_addr0) == a) return wr_data0;
        return mreg[a];
    endfunction

    function automatic logic ref_busy(input int a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && ((wr_en1 && int'(wr_addr1) == a) || (wr_en0 && int'(wr_addr0) == a)))
            return claim_en && int'(claim_addr) == a;
        return mbusy[a];
    endfunction

    function automatic int busy_total();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
        end
    endtask

    // Apply one cycle of stimulus, queue the expected mid-cycle response, then advance the model.
    task automatic cycle(input int rn, input int we0, input int a0, input logic [31:0] d0,
                         input int we1, input int a1, input logic [31:0] d1,
                         input int ce, input int ca, input int r0, input int r1);
        exp_t e;
        @(posedge clock);
        #1;
        reset_n    = (rn != 0);
        wr_en0     = (we0 != 0);
        wr_addr0   = AW'(a0);
        wr_data0   = d0;
        wr_en1     = (we1 != 0);
        wr_addr1   = AW'(a1);
        wr_data1   = d1;
        claim_en   = (ce != 0);
        claim_addr = AW'(ca);
        rd_addr    = {AW'(r1), AW'(r0)};

        e.step    = step;
        e.data    = {ref_data(r1, 1), ref_data(r0, 1)};
        e.busy    = {ref_busy(r1, 1), ref_busy(r0, 1)};
        e.data_nb = {ref_data(r1, 0), ref_data(r0, 0)};
        e.busy_nb = {ref_busy(r1, 0), ref_busy(r0, 0)};
        e.cnt     = 6'(busy_total());
        q.push_back(e);
        step++;

        if (rn == 0) begin
            model_clear();
        end else begin
            if (we0 != 0 && a0 != 0) begin mreg[a0] = d0; mbusy[a0] = 1'b0; end
            if (we1 != 0 && a1 != 0) begin mreg[a1] = d1; mbusy[a1] = 1'b0; end
            if (ce != 0 && ca != 0) mbusy[ca] = 1'b1;
        end
    endtask

    task automatic idle_read(input int r0, input int r1);
        cycle(1, 0, 0, '0, 0, 0, '0, 0, 0, r0, r1);
    endtask

    // Monitor: outputs are combinational/registered with no handshake, so sample every mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("rd_data",       e.step, 64'(rd_data),       e.data);
                chk("rd_busy",       e.step, 64'(rd_busy),       64'(e.busy));
                chk("rd_data_nb",    e.step, 64'(rd_data_nb),    e.data_nb);
                chk("rd_busy_nb",    e.step, 64'(rd_busy_nb),    64'(e.busy_nb));
                chk("busy_count",    e.step, 64'(busy_count),    64'(e.cnt));
                chk("busy_count_nb", e.step, 64'(busy_count_nb), 64'(e.cnt));
            end
        end
    end

    initial begin
        reset_n = 1'b0; wr_en0 = 1'b0; wr_en1 = 1'b0; claim_en = 1'b0;
        wr_addr0 = '0; wr_addr1 = '0; claim_addr = '0;
        wr_data0 = '0; wr_data1 = '0; rd_addr = '0;
        @(posedge clock);
        model_clear();

        cycle(0, 0, 0, '0, 0, 0, '0, 0, 0, 1, 2);
        for (int k = 0; k < 32; k++)
            cycle(1, 1, k, 32'(10 * k), 0, 0, '0, 0, 0, k, (k + 1) % 32);
        for (int k = 0; k < 32; k++)
            idle_read(k, (k + 1) % 32);

        cycle(1, 1, 5, 32'h11, 1, 5, 32'h22, 0, 0, 5, 4);
        idle_read(5, 6);

        cycle(1, 0, 0, '0, 0, 0, '0, 1, 3, 3, 7);
        cycle(1, 0, 0, '0, 0, 0, '0, 1, 7, 3, 7);
        cycle(1, 0, 0, '0, 0, 0, '0, 1, 9, 7, 9);
        idle_read(7, 9);
        cycle(1, 1, 7, 32'h77, 0, 0, '0, 0, 0, 7, 3);
        idle_read(7, 9);

        cycle(1, 0, 0, '0, 1, 4, 32'hAB, 1, 4, 4, 0);
        idle_read(4, 3);

        cycle(1, 1, 0, 32'hDEAD, 1, 0, 32'hBEEF, 1, 0, 0, 4);
        idle_read(0, 9);

        for (int n = 0; n < 400; n++) begin
            int a0 = int'($urandom_range(0, 31));
            int a1 = int'($urandom_range(0, 31));
            int ca = int'($urandom_range(0, 31));
            int r0 = ($urandom_range(0, 3) == 0) ? a1 : int'($urandom_range(0, 31));
            int r1 = ($urandom_range(0, 3) == 0) ? ca : (($urandom_range(0, 3) == 0) ? a0 : int'($urandom_range(0, 31)));
            int rn = ($urandom_range(0, 49) == 0) ? 0 : 1;
            cycle(rn, int'($urandom_range(0, 1)), a0, $urandom(),
                  int'($urandom_range(0, 1)), a1, $urandom(),
                  int'($urandom_range(0, 1)), ca, r0, r1);
        end

        for (int k = 1; k < 6; k++)
            cycle(1, 0, 0, '0, 0, 0, '0, 1, k, k, 0);
        cycle(0, 1, 12, 32'h1234, 1, 13, 32'h5678, 1, 14, 12, 13);
        idle_read(12, 14);
        idle_read(13, 1);

        @(negedge clock);
        #1;
        chk("queue_drained", step, 64'(q.size()), 64'd0);
        done = 1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
